alu_sequencer: RTL and testbench

//  Initiator side of the 8-bit signed ALU interface (A, B, F -> Saida, FLAG_O). Accepts commands over
//  a valid/ready port, drives the ALU operand/select lines from registers, captures result and overflow

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_sequencer_if.sv | 54 +++++
 rtl/alu_ref_model.sv | 32 +++
 rtl/alu_sequencer.sv | 96 +++++++++
 tb/tb_alu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU sequencer
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command, ALU, result and status bundle of the sequencer
interface alu_sequencer_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
);

  // command port
  logic             cmd_valid;
  logic             cmd_ready;
  alu_op_t          cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;

  // ALU lines
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_op_t          alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;

  // result port
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;

  // status
  logic             ovf_sticky;
  logic             alu_err;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;

  // sequencer side: initiator toward the ALU, responder on the command port
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  alu_y, alu_ovf,
    input  res_ready, clr_sticky,
    output cmd_ready, alu_a, alu_b, alu_f,
    output res_valid, res_data, res_ovf,
    output ovf_sticky, alu_err, op_count
  );

  // controller plus ALU side
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output alu_y, alu_ovf,
    output res_ready, clr_sticky,
    input  cmd_ready, alu_a, alu_b, alu_f,
    input  res_valid, res_data, res_ovf,
    input  ovf_sticky, alu_err, op_count
  );

endinterface

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational reference of the signed ALU
module alu_ref_model import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  localparam int MSB = WIDTH - 1;

  // Sums wrap to WIDTH bits; overflow is judged from operand and result signs.
  always_comb begin
    y_o   = '0;
    ovf_o = 1'b0;
    case (op_i)
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_ADD: begin
        y_o   = a_i + b_i;
        ovf_o = (a_i[MSB] == b_i[MSB]) && (y_o[MSB] != a_i[MSB]);
      end
      default: begin
        y_o   = a_i - b_i;
        ovf_o = (a_i[MSB] != b_i[MSB]) && (y_o[MSB] != a_i[MSB]);
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives the ALU, checks its answer and returns the result
module alu_sequencer import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input logic            clock,
  input logic            reset,
  alu_sequencer_if.master bus
);

  seq_state_t       state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  alu_op_t          alu_f_q;
  logic [WIDTH-1:0] res_data_q;   // also serves as the last result for chained commands
  logic             res_ovf_q;
  logic             ovf_sticky_q;
  logic             alu_err_q;
  logic [CNT_W-1:0] op_count_q;

  logic [WIDTH-1:0] alu_a_d;
  logic [CNT_W-1:0] op_count_d;
  logic [WIDTH-1:0] model_y;
  logic             model_ovf;
  logic             mismatch;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i   (alu_a_q),
    .b_i   (alu_b_q),
    .op_i  (alu_f_q),
    .y_o   (model_y),
    .ovf_o (model_ovf)
  );

  assign alu_a_d    = bus.cmd_chain ? res_data_q : bus.cmd_a;
  assign op_count_d = (&op_count_q) ? op_count_q : op_count_q + CNT_W'(1);
  assign mismatch   = (bus.alu_y != model_y) || (bus.alu_ovf != model_ovf);

  // Command -> execute -> response sequencing with captured result and sticky status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= OP_AND;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      alu_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      // Clear first so that a capture in the same cycle overrides it.
      if (bus.clr_sticky) begin
        ovf_sticky_q <= 1'b0;
        alu_err_q    <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q <= alu_a_d;
            alu_b_q <= bus.cmd_b;
            alu_f_q <= bus.cmd_op;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU inputs have been stable for a full cycle here.
          res_data_q <= model_y;
          res_ovf_q  <= model_ovf;
          if (model_ovf) ovf_sticky_q <= 1'b1;
          if (mismatch)  alu_err_q    <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            op_count_q <= op_count_d;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.res_valid  = (state_q == ST_RESP);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_f      = alu_f_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.alu_err    = alu_err_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with an ALU and a faulty-flag stub
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [7:0] y;
    logic       ovf;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       stub_or_flag;
  logic [7:0] last_res;
  logic [7:0] alu_y_m;
  logic       alu_ovf_m;
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_count = 0;

  alu_sequencer_if #(.WIDTH(W), .CNT_W(8)) bus();

  alu_sequencer #(.WIDTH(W), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // free-running clock
  always #5 clock = ~clock;

  // signed 8-bit ALU behaviour, computed with integer range checks
  function automatic void ref_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] y, output logic ovf);
    int sa, sb, r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = 0;
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        r   = sa + sb;
        y   = r[7:0];
        ovf = (r > 127) || (r < -128);
      end
      default: begin
        r   = sa - sb;
        y   = r[7:0];
        ovf = (r > 127) || (r < -128);
      end
    endcase
  endfunction

  // attached ALU; the stub mode raises FLAG_O on OR
  always_comb begin
    alu_y_m   = '0;
    alu_ovf_m = 1'b0;
    ref_op(bus.alu_f, bus.alu_a, bus.alu_b, alu_y_m, alu_ovf_m);
    if (stub_or_flag && (bus.alu_f == OP_OR)) alu_ovf_m = 1'b1;
  end

  assign bus.alu_y   = alu_y_m;
  assign bus.alu_ovf = alu_ovf_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input logic chain,
                      input logic [7:0] ey, input logic eo, input bit push);
    int   budget;
    exp_t e;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = chain;
    bus.cmd_valid = 1'b1;
    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check_eq("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (push) begin
      e.y   = ey;
      e.ovf = eo;
      exp_q.push_back(e);
      last_res = ey;
    end
  endtask

  task automatic collect(input int hold);
    int   budget;
    exp_t e;
    budget = 0;
    while (bus.res_valid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    if (bus.res_valid !== 1'b1) begin
      check_eq("res_valid_timeout", 32'(bus.res_valid), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("hold_data", 32'(bus.res_data), 32'(exp_q[0].y));
      check_eq("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("hold_count", 32'(bus.op_count), exp_count);
    end
    e = exp_q.pop_front();
    check_eq("res_data", 32'(bus.res_data), 32'(e.y));
    check_eq("res_ovf", 32'(bus.res_ovf), 32'(e.ovf));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    exp_count = (exp_count == 255) ? 255 : exp_count + 1;
    check_eq("op_count", 32'(bus.op_count), exp_count);
    check_eq("res_valid_drop", 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb, ey;
    logic [1:0] rop;
    logic       eo, rch;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_AND;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.cmd_chain  = 1'b0;
    bus.res_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    stub_or_flag   = 1'b0;
    last_res       = '0;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check_eq("rst_alu_f", 32'(bus.alu_f), 32'd0);
    check_eq("rst_res_data", 32'(bus.res_data), 32'd0);
    check_eq("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
    check_eq("rst_ovf_sticky", 32'(bus.ovf_sticky), 32'd0);
    check_eq("rst_alu_err", 32'(bus.alu_err), 32'd0);
    check_eq("rst_op_count", 32'(bus.op_count), 32'd0);

    // chain before any result: A is 0, cmd_a ignored
    send(OP_ADD, 8'd99, 8'd5, 1'b1, 8'd5, 1'b0, 1'b1);
    collect(0);

    // ADD 100+27 with latency check
    send(OP_ADD, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b1);
    check_eq("lat_exec_valid", 32'(bus.res_valid), 32'd0);
    check_eq("lat_exec_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    check_eq("lat_resp_valid", 32'(bus.res_valid), 32'd1);
    collect(0);
    check_eq("err_clean", 32'(bus.alu_err), 32'd0);
    check_eq("sticky_clean", 32'(bus.ovf_sticky), 32'd0);

    // signed overflow boundaries
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1);
    collect(0);
    check_eq("ovf_sticky_add", 32'(bus.ovf_sticky), 32'd1);
    send(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    collect(0);

    // chained pair and bitwise op
    send(OP_ADD, 8'd5, 8'd3, 1'b0, 8'd8, 1'b0, 1'b1);
    collect(0);
    send(OP_SUB, 8'h55, 8'd10, 1'b1, 8'hFE, 1'b0, 1'b1);
    collect(0);
    send(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b1);
    collect(0);

    // consumer stalls five cycles, then keeps res_ready high one extra cycle
    send(OP_OR, 8'h0F, 8'hA0, 1'b0, 8'hAF, 1'b0, 1'b1);
    collect(5);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("count_once", 32'(bus.op_count), exp_count);

    // clear sticky bits
    bus.clr_sticky = 1'b1;
    tick();
    bus.clr_sticky = 1'b0;
    check_eq("clr_ovf_sticky", 32'(bus.ovf_sticky), 32'd0);
    check_eq("clr_alu_err", 32'(bus.alu_err), 32'd0);

    // faulty ALU flags overflow on OR
    stub_or_flag = 1'b1;
    send(OP_OR, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
    collect(0);
    check_eq("stub_alu_err", 32'(bus.alu_err), 32'd1);
    check_eq("stub_no_sticky", 32'(bus.ovf_sticky), 32'd0);
    stub_or_flag = 1'b0;

    // clear held across a new overflow capture: the set wins
    bus.clr_sticky = 1'b1;
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1);
    tick();
    check_eq("setwins_ovf_sticky", 32'(bus.ovf_sticky), 32'd1);
    check_eq("setwins_alu_err", 32'(bus.alu_err), 32'd0);
    bus.clr_sticky = 1'b0;
    collect(0);

    // random mix, occasionally chained and stalled
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rch = ($urandom_range(0, 3) == 0);
      ref_op(alu_op_t'(rop), rch ? last_res : ra, rb, ey, eo);
      send(alu_op_t'(rop), ra, rb, rch, ey, eo, 1'b1);
      collect($urandom_range(0, 2));
    end
    check_eq("rand_alu_err", 32'(bus.alu_err), 32'd0);

    // drive the counter into saturation
    for (int n = 0; n < 260; n++) begin
      send(OP_AND, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1);
      collect(0);
    end
    check_eq("op_count_sat", 32'(bus.op_count), 32'd255);

    // reset while the command is in EXEC
    send(OP_ADD, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("rst_exec_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_exec_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_exec_op_count", 32'(bus.op_count), 32'd0);
    check_eq("rst_exec_sticky", 32'(bus.ovf_sticky), 32'd0);
    tick();
    reset     = 1'b0;
    exp_count = 0;
    last_res  = '0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_eq("rst_no_result", 32'(bus.res_valid), 32'd0);
    end

    // chain after reset starts from 0
    send(OP_SUB, 8'h40, 8'd3, 1'b1, 8'hFD, 1'b0, 1'b1);
    collect(0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
